axil_uart_arbiter: RTL and testbench

Two-master AXI4-Lite arbiter that shares the single AXI4-Lite slave port of the UART bridge between two requesters (e.g. CPU and DMA).
- One transaction (read or write) outstanding on the slave at a time.
- Round-robin between masters; write-before-read within a master.
- Sits between the interconnect masters and the UART slave, all on clk.

---
 rtl/axil_uart_arbiter_if.sv | 37 +++
 rtl/axil_uart_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axil_uart_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_uart_arbiter_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R) shared by the arbiter's master-facing and slave-facing ports.
// No logic, so no latency of its own.
// Backpressure is the plain AXI valid/ready of each channel.
interface axil_uart_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   // The side that issues requests.
   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   // The side that answers requests.
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_uart_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the UART bridge slave: round-robin, one transaction in flight.
// Latency: one IDLE arbitration cycle per transaction; channels pass through combinationally inside a phase.
// Backpressure: the non-granted master sees ready=0 and valid=0 and waits; optional watchdog under AXIL_ARB_TIMEOUT_EN.
module axil_uart_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   axil_uart_arbiter_if.slave  m0,
   axil_uart_arbiter_if.slave  m1,
   axil_uart_arbiter_if.master s_axi,
   output logic [1:0]         grant,
   output logic               timeout_flag
);

   typedef enum logic [2:0] {IDLE, W_ADDR_DATA, W_RESP, R_ADDR, R_DATA} state_t;

   // The watchdog counter is 16 bits wide, so the limit must fit in it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range for 16-bit watchdog");
   end

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       rr_ptr_q, rr_ptr_d;
   logic [1:0] grant_q, grant_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;

   logic       req0, req1, win;
   logic       aw_hs, w_hs;
   logic       to_hit;   // watchdog expired: arbiter answers on the slave's behalf
   logic       absorb;   // IDLE drains late slave responses

   // Signals of whichever master currently owns the slave.
   logic [ADDR_W-1:0] sel_awaddr, sel_araddr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_wstrb;
   logic              sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

   // Owner-side response/ready values before being steered to m0 or m1.
   logic              o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
   logic [1:0]        o_bresp, o_rresp;
   logic [DATA_W-1:0] o_rdata;

   // Slave-side valids/readies.
   logic              s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

   assign req0 = m0.awvalid | m0.arvalid;
   assign req1 = m1.awvalid | m1.arvalid;

   assign sel_awaddr  = owner_q ? m1.awaddr  : m0.awaddr;
   assign sel_awvalid = owner_q ? m1.awvalid : m0.awvalid;
   assign sel_wdata   = owner_q ? m1.wdata   : m0.wdata;
   assign sel_wstrb   = owner_q ? m1.wstrb   : m0.wstrb;
   assign sel_wvalid  = owner_q ? m1.wvalid  : m0.wvalid;
   assign sel_bready  = owner_q ? m1.bready  : m0.bready;
   assign sel_araddr  = owner_q ? m1.araddr  : m0.araddr;
   assign sel_arvalid = owner_q ? m1.arvalid : m0.arvalid;
   assign sel_rready  = owner_q ? m1.rready  : m0.rready;

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] cnt_q, cnt_d;
   logic        timeout_flag_q;

   assign to_hit = (state_q == W_RESP || state_q == R_DATA) && (cnt_q >= TO_LIMIT);
   assign absorb = 1'b1;

   // Counter is zero outside the response phases, so it starts from 0 on every entry; it saturates at the limit.
   assign cnt_d = (state_q == W_RESP || state_q == R_DATA) ?
                  (to_hit ? cnt_q : cnt_q + 16'd1) : 16'd0;

   // Watchdog counter and sticky flag, set when the synthesized error response is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= 16'd0;
         timeout_flag_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         timeout_flag_q <= timeout_flag_q |
                           (to_hit && state_q == W_RESP && sel_bready) |
                           (to_hit && state_q == R_DATA && sel_rready);
      end
   end

   assign timeout_flag = timeout_flag_q;
`else
   assign to_hit       = 1'b0;
   assign absorb       = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   // State, owner, round-robin pointer, grant and write-phase done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         rr_ptr_q  <= 1'b0;
         grant_q   <= 2'b00;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state, arbitration and per-phase channel routing.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      win       = 1'b0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      o_awready = 1'b0;
      o_wready  = 1'b0;
      o_bvalid  = 1'b0;
      o_bresp   = 2'b00;
      o_arready = 1'b0;
      o_rvalid  = 1'b0;
      o_rdata   = '0;
      o_rresp   = 2'b00;

      case (state_q)
         IDLE: begin
            s_bready = absorb;
            s_rready = absorb;
            if (req0 | req1) begin
               // With both requesting the pointer decides; with one, req1 alone names the winner.
               win     = (req0 & req1) ? rr_ptr_q : req1;
               owner_d = win;
               grant_d = win ? 2'b10 : 2'b01;
               state_d = (win ? m1.awvalid : m0.awvalid) ? W_ADDR_DATA : R_ADDR;
            end
         end

         W_ADDR_DATA: begin
            s_awvalid = sel_awvalid & ~aw_done_q;
            s_wvalid  = sel_wvalid  & ~w_done_q;
            o_awready = s_axi.awready & ~aw_done_q;
            o_wready  = s_axi.wready  & ~w_done_q;
            aw_hs     = s_awvalid & s_axi.awready;
            w_hs      = s_wvalid  & s_axi.wready;
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               state_d   = W_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q  | w_hs;
            end
         end

         W_RESP: begin
            if (to_hit) begin
               o_bvalid = 1'b1;
               o_bresp  = 2'b10;
               if (sel_bready) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
                  grant_d  = 2'b00;
               end
            end else begin
               s_bready = sel_bready;
               o_bvalid = s_axi.bvalid;
               o_bresp  = s_axi.bresp;
               if (s_axi.bvalid & sel_bready) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
                  grant_d  = 2'b00;
               end
            end
         end

         R_ADDR: begin
            s_arvalid = sel_arvalid;
            o_arready = s_axi.arready;
            if (sel_arvalid & s_axi.arready) begin
               state_d = R_DATA;
            end
         end

         R_DATA: begin
            if (to_hit) begin
               o_rvalid = 1'b1;
               o_rresp  = 2'b10;
               if (sel_rready) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
                  grant_d  = 2'b00;
               end
            end else begin
               s_rready = sel_rready;
               o_rvalid = s_axi.rvalid;
               o_rdata  = s_axi.rdata;
               o_rresp  = s_axi.rresp;
               if (s_axi.rvalid & sel_rready) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
                  grant_d  = 2'b00;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign grant = grant_q;

   // Slave side: payloads come straight from the owner, valids/readies from the phase logic.
   assign s_axi.awaddr  = sel_awaddr;
   assign s_axi.awvalid = s_awvalid;
   assign s_axi.wdata   = sel_wdata;
   assign s_axi.wstrb   = sel_wstrb;
   assign s_axi.wvalid  = s_wvalid;
   assign s_axi.bready  = s_bready;
   assign s_axi.araddr  = sel_araddr;
   assign s_axi.arvalid = s_arvalid;
   assign s_axi.rready  = s_rready;

   // Master side: the non-owner always sees zeros.
   assign m0.awready = ~owner_q & o_awready;
   assign m0.wready  = ~owner_q & o_wready;
   assign m0.bvalid  = ~owner_q & o_bvalid;
   assign m0.bresp   = owner_q ? 2'b00 : o_bresp;
   assign m0.arready = ~owner_q & o_arready;
   assign m0.rvalid  = ~owner_q & o_rvalid;
   assign m0.rdata   = owner_q ? '0 : o_rdata;
   assign m0.rresp   = owner_q ? 2'b00 : o_rresp;

   assign m1.awready = owner_q & o_awready;
   assign m1.wready  = owner_q & o_wready;
   assign m1.bvalid  = owner_q & o_bvalid;
   assign m1.bresp   = owner_q ? o_bresp : 2'b00;
   assign m1.arready = owner_q & o_arready;
   assign m1.rvalid  = owner_q & o_rvalid;
   assign m1.rdata   = owner_q ? o_rdata : '0;
   assign m1.rresp   = owner_q ? o_rresp : 2'b00;

endmodule

// File: tb/tb_axil_uart_arbiter.sv
// Directed bench for axil_uart_arbiter: writes, reads, round-robin, split AW/W, async reset, watchdog.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later or on the falling edge.
// Build with AXIL_ARB_TIMEOUT_EN defined to exercise the watchdog with an 8-cycle limit.
module tb_axil_uart_arbiter;

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 1024;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;
   logic       timeout_flag;

   int n_tests = 0;
   int n_fail  = 0;
   int n;
   int aw_cnt, w_cnt, wresp_cyc;
   logic m0_aw_acc, m0_w_acc;

   axil_uart_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   axil_uart_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   axil_uart_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

   axil_uart_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0           (m0_if),
      .m1           (m1_if),
      .s_axi        (s_if),
      .grant        (grant),
      .timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      m0_if.awaddr = '0; m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wvalid = 0;
      m0_if.bready = 0; m0_if.araddr = '0; m0_if.arvalid = 0; m0_if.rready = 0;
      m1_if.awaddr = '0; m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wvalid = 0;
      m1_if.bready = 0; m1_if.araddr = '0; m1_if.arvalid = 0; m1_if.rready = 0;
      s_if.awready = 0; s_if.wready = 0; s_if.bresp = 2'b00; s_if.bvalid = 0;
      s_if.arready = 0; s_if.rdata = '0; s_if.rresp = 2'b00; s_if.rvalid = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      tick();
      tick();

      // Reset state
      chk("rst_grant",    grant, 2'b00);
      chk("rst_tflag",    timeout_flag, 1'b0);
      chk("rst_m0_awrdy", m0_if.awready, 1'b0);
      chk("rst_m1_wrdy",  m1_if.wready, 1'b0);
      chk("rst_m0_bvld",  m0_if.bvalid, 1'b0);
      chk("rst_m1_rvld",  m1_if.rvalid, 1'b0);
      chk("rst_m0_rdata", m0_if.rdata, 32'h0);
      chk("rst_s_awvld",  s_if.awvalid, 1'b0);
      chk("rst_s_arvld",  s_if.arvalid, 1'b0);
      rst_n = 1'b1;
      tick();

      // 1: m0 single write, AW and W together
      m0_if.awaddr = 32'hFFE8_0000; m0_if.awvalid = 1;
      m0_if.wdata = 32'h0000_0041; m0_if.wstrb = 4'hF; m0_if.wvalid = 1;
      s_if.awready = 1; s_if.wready = 1;
      #1;
      chk("t1_idle_s_awvld", s_if.awvalid, 1'b0);
      chk("t1_idle_grant", grant, 2'b00);
      tick();
      chk("t1_grant", grant, 2'b01);
      chk("t1_s_awvld", s_if.awvalid, 1'b1);
      chk("t1_s_awaddr", s_if.awaddr, 32'hFFE8_0000);
      chk("t1_s_wdata", s_if.wdata, 32'h0000_0041);
      chk("t1_s_wvld", s_if.wvalid, 1'b1);
      chk("t1_m0_awrdy", m0_if.awready, 1'b1);
      chk("t1_m1_awrdy", m1_if.awready, 1'b0);
      tick();
      m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.bready = 1;
      s_if.bvalid = 1; s_if.bresp = 2'b00;
      #1;
      chk("t1_m0_bvld", m0_if.bvalid, 1'b1);
      chk("t1_m0_bresp", m0_if.bresp, 2'b00);
      chk("t1_s_brdy", s_if.bready, 1'b1);
      chk("t1_m1_bvld", m1_if.bvalid, 1'b0);
      tick();
      s_if.bvalid = 0; m0_if.bready = 0;
      #1;
      chk("t1_grant_idle", grant, 2'b00);
      chk("t1_m0_bvld_idle", m0_if.bvalid, 1'b0);

      // 2: m1 read
      m1_if.araddr = 32'hFFE8_0004; m1_if.arvalid = 1; s_if.arready = 1;
      tick();
      chk("t2_grant", grant, 2'b10);
      chk("t2_s_arvld", s_if.arvalid, 1'b1);
      chk("t2_s_araddr", s_if.araddr, 32'hFFE8_0004);
      chk("t2_m1_arrdy", m1_if.arready, 1'b1);
      chk("t2_m0_arrdy_a", m0_if.arready, 1'b0);
      tick();
      m1_if.arvalid = 0; m1_if.rready = 1;
      s_if.rvalid = 1; s_if.rdata = 32'h0000_0005; s_if.rresp = 2'b00;
      #1;
      chk("t2_m1_rvld", m1_if.rvalid, 1'b1);
      chk("t2_m1_rdata", m1_if.rdata, 32'h0000_0005);
      chk("t2_m1_rresp", m1_if.rresp, 2'b00);
      chk("t2_m0_rvld", m0_if.rvalid, 1'b0);
      chk("t2_m0_arrdy_d", m0_if.arready, 1'b0);
      tick();
      s_if.rvalid = 0; m1_if.rready = 0;
      #1;
      chk("t2_grant_idle", grant, 2'b00);
      clear_inputs();

      // 3: both masters write continuously after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.bready = 1; m0_if.awaddr = 32'hFFE8_0000;
      m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.bready = 1; m1_if.awaddr = 32'hFFE8_0010;
      s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1;
      for (int t = 0; t < 6; t++) begin
         n = 0;
         while (grant === 2'b00 && n < 10) begin tick(); n++; end
         chk($sformatf("t3_grant%0d", t), grant, (t % 2 == 1) ? 2'b10 : 2'b01);
         n = 0;
         while (grant !== 2'b00 && n < 10) begin tick(); n++; end
         chk($sformatf("t3_release%0d", t), grant, 2'b00);
      end
      clear_inputs();
      tick();

      // 4: m0 AW in cycle 3, W in cycle 7
      s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1; m0_if.bready = 1;
      m0_if.awaddr = 32'hFFE8_0000; m0_if.wdata = 32'h0000_0042; m0_if.wstrb = 4'hF;
      aw_cnt = 0; w_cnt = 0; wresp_cyc = -1; m0_aw_acc = 0; m0_w_acc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 3) m0_if.awvalid = 1; else if (m0_aw_acc) m0_if.awvalid = 0;
         if (cyc == 7) m0_if.wvalid = 1;  else if (m0_w_acc)  m0_if.wvalid = 0;
         @(negedge clk);
         m0_aw_acc = m0_if.awvalid & m0_if.awready;
         m0_w_acc  = m0_if.wvalid & m0_if.wready;
         if (s_if.awvalid & s_if.awready) aw_cnt++;
         if (s_if.wvalid & s_if.wready) w_cnt++;
         if (m0_if.bvalid === 1'b1 && wresp_cyc < 0) wresp_cyc = cyc;
      end
      chk("t4_aw_once", aw_cnt, 1);
      chk("t4_w_once", w_cnt, 1);
      chk("t4_wresp_cyc", wresp_cyc, 8);
      clear_inputs();
      tick();

      // 5: async reset during R_DATA, then a normal m0 read
      m0_if.araddr = 32'hFFE8_0004; m0_if.arvalid = 1; s_if.arready = 1;
      tick();
      tick();
      m0_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h0000_00AA;
      #1;
      chk("t5_rdata_pre", m0_if.rvalid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_rvld", m0_if.rvalid, 1'b0);
      chk("t5_rst_rdata", m0_if.rdata, 32'h0);
      chk("t5_rst_grant", grant, 2'b00);
      chk("t5_rst_s_arvld", s_if.arvalid, 1'b0);
      tick();
      rst_n = 1'b1;
      s_if.rvalid = 0;
      m0_if.araddr = 32'hFFE8_0008; m0_if.arvalid = 1;
      tick();
      chk("t5_grant", grant, 2'b01);
      chk("t5_m0_arrdy", m0_if.arready, 1'b1);
      tick();
      m0_if.arvalid = 0; m0_if.rready = 1; s_if.rvalid = 1; s_if.rdata = 32'h0000_0033;
      #1;
      chk("t5_m0_rvld", m0_if.rvalid, 1'b1);
      chk("t5_m0_rdata", m0_if.rdata, 32'h0000_0033);
      tick();
      chk("t5_grant_idle", grant, 2'b00);
      clear_inputs();
      tick();

      // 6: slave never answers the write
      m0_if.awaddr = 32'hFFE8_0000; m0_if.awvalid = 1; m0_if.wdata = 32'h0000_0043;
      m0_if.wstrb = 4'hF; m0_if.wvalid = 1;
      s_if.awready = 1; s_if.wready = 1;
      tick();
      chk("t6_grant", grant, 2'b01);
      tick();
      m0_if.awvalid = 0; m0_if.wvalid = 0;
      #1;
      n = 0;
      while (m0_if.bvalid !== 1'b1 && n < 20) begin tick(); n++; end
`ifdef AXIL_ARB_TIMEOUT_EN
      chk("t6_to_cycles", n, 8);
      chk("t6_bresp", m0_if.bresp, 2'b10);
      chk("t6_tflag_pre", timeout_flag, 1'b0);
      tick();
      chk("t6_bvld_hold", m0_if.bvalid, 1'b1);
      m0_if.bready = 1;
      tick();
      m0_if.bready = 0;
      chk("t6_tflag", timeout_flag, 1'b1);
      chk("t6_grant_idle", grant, 2'b00);
      s_if.bvalid = 1; s_if.bresp = 2'b00;
      #1;
      chk("t6_late_m0_bvld", m0_if.bvalid, 1'b0);
      chk("t6_late_s_brdy", s_if.bready, 1'b1);
      tick();
      s_if.bvalid = 0;
      tick();
      chk("t6_tflag_sticky", timeout_flag, 1'b1);
`else
      chk("t6_wait_cycles", n, 20);
      chk("t6_wait_grant", grant, 2'b01);
      chk("t6_tflag", timeout_flag, 1'b0);
      s_if.bvalid = 1; s_if.bresp = 2'b00; m0_if.bready = 1;
      #1;
      chk("t6_bvld", m0_if.bvalid, 1'b1);
      chk("t6_bresp", m0_if.bresp, 2'b00);
      tick();
      chk("t6_grant_idle", grant, 2'b00);
      s_if.bvalid = 0; m0_if.bready = 0;
`endif
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
